// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The optional parity feature is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int unsigned UART_MAX_DATA_BITS = 8;

  // Unused high bits must be zero; odd selects inverted (odd) parity.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes ahead of the UART serializer.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-buffered bytes serialized as start/data/[parity]/stop frames.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  uart_tx_state_e         state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   baud_last;
  logic                   load_frame;

  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;

`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
  logic [UART_MAX_DATA_BITS-1:0] parity_src;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign baud_last = (baud_q == BAUD_LAST);

  // tx_d always carries the level of the state being entered, so the
  // registered line changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
    parity_src = '0;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = UART_IDLE_LEVEL;
        baud_d = '0;
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end
      end

      START: begin
        if (baud_last) begin
          state_d   = DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d    = STOP;
            stop_idx_d = 1'b0;
            tx_d       = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_d    = STOP;
          baud_d     = '0;
          stop_idx_d = 1'b0;
          tx_d       = UART_IDLE_LEVEL;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            if (!fifo_empty) begin
              load_frame = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = UART_IDLE_LEVEL;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase

    // Shared by IDLE and the end of STOP: back-to-back frames skip IDLE.
    if (load_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_data;
      state_d  = START;
      baud_d   = '0;
      tx_d     = UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_src[DATA_BITS-1:0] = fifo_data;
      parity_d = uart_parity(parity_src, PARITY_ODD);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame-level reference model plus
// directed scenarios (single byte, back-to-back, collision, mid-frame reset, 2 stop bits).
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int SB    = 1;
  localparam int SB2   = 2;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL  = (1 + DB + P + SB)  * CPB;
  localparam int FL2 = (1 + DB + P + SB2) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_count;

  logic [7:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;
  logic [2:0] fifo_count2;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (SB2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .fifo_count (fifo_count2)
  );

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: queued bytes plus the frame currently on the line.
  logic [7:0] mq[$];
  bit         active = 1'b0;
  int         fstart = 0;
  logic [7:0] fbyte = '0;
  int         ecount = 0;
  bit         accepted = 1'b0;

  // Line level at a given clock offset inside a frame.
  function automatic logic exp_bit(input logic [7:0] b, input int off);
    int k;
    k = off / CPB;
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    if (P == 1 && k == DB + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    ecount++;
    accepted = tx_valid && (mq.size() != DEPTH);
    if (!active || ecount == fstart + FL) begin
      if (mq.size() > 0) begin
        fbyte  = mq.pop_front();
        fstart = ecount;
        active = 1'b1;
      end else begin
        active = 1'b0;
      end
    end
    if (accepted) mq.push_back(tx_data);
    #1;
    check("tx", tx, active ? exp_bit(fbyte, ecount - fstart) : 1'b1);
    check("fifo_count", fifo_count, mq.size());
    check("tx_ready", tx_ready, mq.size() != DEPTH);
    check("busy", busy, active || mq.size() != 0);
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    repeat (n) begin
      tx_data = 8'($urandom);
      step();
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic reset_mid_frame(input int bitpos);
    int guard;
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    guard = 0;
    while (ecount != fstart + (1 + bitpos) * CPB + 1 && guard < 2 * FL) begin
      idle(1);
      guard++;
    end
    check("midrst_wait", guard < 2 * FL, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    active = 1'b0;
    push(8'h55);
    idle(FL + 5);
  endtask

  task automatic check_dut2(input int n0);
    bit in_f1, in_f2;
    logic exp_tx;
    in_f1 = (ecount >= n0 + 1) && (ecount < n0 + 1 + FL2);
    in_f2 = (ecount >= n0 + 1 + FL2) && (ecount < n0 + 1 + 2 * FL2);
    if (in_f1)      exp_tx = exp_bit(8'hFF, ecount - (n0 + 1));
    else if (in_f2) exp_tx = exp_bit(8'hFF, ecount - (n0 + 1 + FL2));
    else            exp_tx = 1'b1;
    check("sb2_tx", tx2, exp_tx);
    check("sb2_busy", busy2, (ecount >= n0) && (ecount < n0 + 1 + 2 * FL2));
    check("sb2_count", fifo_count2, (ecount >= n0) && (ecount < n0 + 1 + FL2));
    check("sb2_ready", tx_ready2, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, n0;
    bit saw_full;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_tx2", tx2, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    push(8'hA5);
    idle(FL + 5);

    push(8'h07);
    idle(FL + 5);
    push(8'h03);
    idle(FL + 5);

    // Back-to-back stream 0x01..0x06 with tx_valid held.
    n = 1;
    saw_full = 1'b0;
    guard = 0;
    tx_valid = 1'b1;
    tx_data  = 8'd1;
    while (n <= 6 && guard < 500) begin
      step();
      guard++;
      if (fifo_count == 3'd4 && !tx_ready) saw_full = 1'b1;
      if (accepted) begin
        n++;
        tx_data = 8'(n);
      end
    end
    tx_valid = 1'b0;
    check("b2b_full_seen", saw_full, 1'b1);
    check("b2b_pushed", n, 7);
    idle(6 * FL + 10);

    // Push lands on the same edge that ends STOP and pops.
    push(8'h81);
    push(8'h82);
    push(8'h83);
    guard = 0;
    while (ecount + 1 != fstart + FL && guard < 2 * FL) begin
      idle(1);
      guard++;
    end
    check("collide_wait", guard < 2 * FL, 1'b1);
    push(8'h84);
    check("collide_count", fifo_count, 2);
    idle(3 * FL + 10);

    reset_mid_frame(3);
    reset_mid_frame(0);

    // Two stop bits on the second instance.
    tx_valid2 = 1'b1;
    tx_data2  = 8'hFF;
    step();
    n0 = ecount;
    check_dut2(n0);
    step();
    tx_valid2 = 1'b0;
    check_dut2(n0);
    while (ecount < n0 + 2 * FL2 + 4) begin
      tx_data2 = 8'($urandom);
      step();
      check_dut2(n0);
    end

    // Randomized traffic at several load levels.
    foreach (mq[i]) begin end
    for (int blk = 0; blk < 3; blk++) begin
      int pct;
      pct = (blk == 0) ? 10 : (blk == 1) ? 50 : 95;
      repeat (1000) begin
        tx_valid = ($urandom_range(0, 99) < pct);
        tx_data  = 8'($urandom);
        step();
      end
    end
    idle(5 * FL + 10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit-side block that drives the serial `tx` line observed on the UART pin interface. Parallel bytes arrive over a valid/ready handshake and are buffered in a small FIFO. Each byte is serialized as 8N1-style frames: start bit, data bits LSB first, optional parity, then stop bit(s). The bit period is a fixed number of clocks. The block sits between the core datapath and the `tx` pin.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5 to 8.
- FIFO_DEPTH, 4: entries in the input FIFO; power of 2, ≥ 2.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: asynchronous, active-high reset.
- tx_data, input, DATA_BITS: byte to send.
- tx_valid, input, 1: tx_data is valid this cycle.
- tx_ready, output, 1: FIFO can accept a byte.
- tx, output, 1: serial line; idle high.
- busy, output, 1: a frame is in progress or the FIFO is non-empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset values (asynchronous assert, synchronous release): tx=1, tx_ready=1, busy=0, fifo_count=0. The FSM goes to IDLE and all counters clear.
- Push: a byte is accepted on a rising clk edge where tx_valid && tx_ready.
- tx_ready is combinational and equals (fifo_count != FIFO_DEPTH).
- No push occurs while the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full leaves fifo_count unchanged.
- tx is a registered output.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: when fifo_count > 0, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right, for DATA_BITS bits.
  - After DATA: go to PARITY if the optional feature is enabled, otherwise go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP:
  - If the FIFO is non-empty, pop and enter START directly. There is zero idle cycles between frames.
  - Otherwise go to IDLE.
- Latency: for a byte pushed at edge N into an empty, idle block, the pop occurs in IDLE at edge N+1 and tx falls at edge N+1 (registered). The frame occupies exactly (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 when parity is enabled and 0 otherwise.
- Counters:
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit index counter counts 0..DATA_BITS-1.
  - Widths use $clog2 and must not overflow at the maximum parameter values.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_count distinguishes full from empty.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the FIFO is flushed, and the partial frame is dropped.
- tx_data is ignored when tx_valid=0. Its value while tx_valid=0 does not matter.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds a parameter PARITY_ODD (default 0).
  - The PARITY state transmits one bit for CLKS_PER_BIT cycles.
  - With PARITY_ODD=0 (even parity), the parity bit is the XOR of all data bits; with PARITY_ODD=1 it is the inverted XOR.
  - The parity bit is computed at pop time.
- When undefined: the PARITY state and parity logic are absent, and DATA goes directly to STOP.

Decomposition:
- Package uart_pkg contains:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants UART_IDLE_LEVEL=1'b1 and UART_START_LEVEL=1'b0;
  - a parity helper function.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterized by width and depth, on the same clk/rst.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0xA5 while idle.
  - tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - busy drops on the cycle after the stop bit ends.
- Back-to-back frames: hold tx_valid with 0x01..0x06.
  - tx_ready goes low when fifo_count reaches 4.
  - All 6 frames appear contiguously, with no idle-high gap beyond the stop bit.
  - Bytes come out in order.
- Push/pop collision: push a byte on the same cycle the end of STOP pops from a FIFO holding 2 entries.
  - fifo_count stays at 2.
  - No byte is lost or duplicated.
- Reset mid-frame: assert rst during the DATA bit 3 of 0x3C, with 2 entries queued.
  - tx=1 immediately; fifo_count=0; busy=0.
  - The next push of 0x55 produces a clean frame.
- STOP_BITS=2: push 0xFF.
  - The stop high period is 8 cycles at CLKS_PER_BIT=4.
  - The next frame's start bit begins exactly after those 8 cycles.
- With UART_TX_PARITY_EN and PARITY_ODD=0:
  - 0x07 gives parity bit 1.
  - 0x03 gives parity bit 0.
  - The frame length is 44 cycles at CLKS_PER_BIT=4.
